// File: rtl/hex_display_pkg.sv
`default_nettype none
// =============================================================================
// hex_display_pkg -- display modes, blank code and active-high 0-F glyphs
// Rev 1.0
// =============================================================================
package hex_display_pkg;

  typedef enum logic [1:0] {
    MODE_HEX    = 2'd0,
    MODE_RAW    = 2'd1,
    MODE_SCROLL = 2'd2,
    MODE_BLANK  = 2'd3
  } mode_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Bit 0 = segment a; entry 15 is listed first.
  localparam logic [15:0][6:0] SEG_GLYPH = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage
`default_nettype wire

// File: rtl/hex_display_ctrl_seg7_decode.sv
`default_nettype none
// =============================================================================
// seg7_decode -- nibble to active-high seven-segment glyph
// Rev 1.0
// =============================================================================
module seg7_decode
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_GLYPH[nibble];

endmodule
`default_nettype wire

// File: rtl/hex_display_ctrl.sv
`default_nettype none
// =============================================================================
// hex_display_ctrl -- multi-digit 7-seg driver: HEX/RAW/SCROLL/BLANK modes.
// Optional blinking via HEX_DISPLAY_BLINK_EN.  Rev 1.0
// =============================================================================
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int TICK_DIV   = 12500000,
  parameter int MSG_DEPTH  = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [1:0]                  mode,
  input  logic [4*NUM_DIGITS-1:0]     value,
  input  logic [7*NUM_DIGITS-1:0]     raw_seg,
  input  logic                        blink_en,
  input  logic                        char_valid,
  output logic                        char_ready,
  input  logic [6:0]                  char_seg,
  input  logic                        msg_clear,
  output logic [$clog2(MSG_DEPTH):0]  msg_count,
  output logic [7*NUM_DIGITS-1:0]     hex_n
);

  localparam int c_aw = $clog2(MSG_DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam int c_tw = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  mode_e                   w_mode;
  logic [c_tw-1:0]         r_tick_cnt;
  logic                    w_tick;
  logic [6:0]              r_buf [MSG_DEPTH];
  logic [c_cw-1:0]         r_msg_count;
  logic [c_cw-1:0]         r_ptr;
  logic                    r_ready_en;
  mode_e                   r_prev_mode;
  logic                    w_full;
  logic                    w_push;
  logic                    w_scroll;
  logic                    w_enter;
  logic                    w_advance;
  logic [7*NUM_DIGITS-1:0] w_hex_seg;
  logic [7*NUM_DIGITS-1:0] w_scroll_seg;
  logic [7*NUM_DIGITS-1:0] w_next_hex;
  logic [7*NUM_DIGITS-1:0] r_hex_n;

  assign w_mode = mode_e'(mode);

  assign w_tick = (r_tick_cnt == c_tw'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset_n)    r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + c_tw'(1);
  end

  assign w_full     = (r_msg_count == c_cw'(MSG_DEPTH));
  assign char_ready = r_ready_en && !w_full && !msg_clear;
  assign w_push     = char_valid && char_ready;
  assign w_scroll   = (w_mode == MODE_SCROLL);
  assign w_enter    = w_scroll && (r_prev_mode != MODE_SCROLL);
  assign w_advance  = w_tick && w_scroll && (r_msg_count > c_cw'(NUM_DIGITS));
  assign msg_count  = r_msg_count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_msg_count <= '0;
      r_ptr       <= '0;
      r_ready_en  <= 1'b0;
      r_prev_mode <= MODE_HEX;
    end else begin
      r_ready_en  <= 1'b1;
      r_prev_mode <= w_mode;
      if (msg_clear)   r_msg_count <= '0;
      else if (w_push) r_msg_count <= r_msg_count + c_cw'(1);
      // Entering scroll restarts the message even if a tick lands on the same edge.
      if (msg_clear || w_enter) r_ptr <= '0;
      else if (w_advance)       r_ptr <= (r_ptr == r_msg_count - c_cw'(1)) ? '0 : r_ptr + c_cw'(1);
    end
  end

  // Buffer contents need no reset: msg_count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_buf[r_msg_count[c_aw-1:0]] <= char_seg;
  end

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    localparam int c_k = NUM_DIGITS - 1 - d;
    logic [c_cw:0]   w_sum;
    logic [c_cw:0]   w_cnt_ext;
    logic [c_aw-1:0] w_idx;

    seg7_decode u_seg7_decode (
      .nibble (value[4*d +: 4]),
      .seg    (w_hex_seg[7*d +: 7])
    );

    // ptr < count and k < count, so one conditional subtract gives the modulo.
    assign w_cnt_ext = {1'b0, r_msg_count};
    assign w_sum     = {1'b0, r_ptr} + (c_cw+1)'(c_k);
    assign w_idx     = c_aw'((w_sum >= w_cnt_ext) ? (w_sum - w_cnt_ext) : w_sum);
    assign w_scroll_seg[7*d +: 7] = ((c_cw+1)'(c_k) < w_cnt_ext) ? r_buf[w_idx] : SEG_BLANK;
  end

`ifdef HEX_DISPLAY_BLINK_EN
  logic r_blink_phase;

  always_ff @(posedge clk) begin
    if (!reset_n)      r_blink_phase <= 1'b0;
    else if (!blink_en) r_blink_phase <= 1'b0;
    else if (w_tick)   r_blink_phase <= ~r_blink_phase;
  end
`else
  logic w_unused_blink;
  assign w_unused_blink = blink_en;
`endif

  always_comb begin
    w_next_hex = '1;
    case (w_mode)
      MODE_HEX:    w_next_hex = ~w_hex_seg;
      MODE_RAW:    w_next_hex = ~raw_seg;
      MODE_SCROLL: w_next_hex = ~w_scroll_seg;
      default:     w_next_hex = '1;
    endcase
`ifdef HEX_DISPLAY_BLINK_EN
    if (r_blink_phase) w_next_hex = '1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_hex_n <= '1;
    else          r_hex_n <= w_next_hex;
  end

  assign hex_n = r_hex_n;

endmodule
`default_nettype wire

// File: tb/tb_hex_display_ctrl.sv
`default_nettype none
// =============================================================================
// tb_hex_display_ctrl -- directed, scoreboard-checked bench for hex_display_ctrl
// Rev 1.0
// =============================================================================
module tb_hex_display_ctrl;

  localparam int ND = 6;
  localparam int TD = 4;
  localparam int MD = 16;

  localparam logic [41:0] ALL     = {42{1'b1}};
  localparam logic [41:0] H0123AF = {7'b1000000, 7'b1111001, 7'b0100100,
                                     7'b0110000, 7'b0001000, 7'b0001110};
  localparam logic [41:0] H456789 = {7'b0011001, 7'b0010010, 7'b0000010,
                                     7'b1111000, 7'b0000000, 7'b0010000};
  localparam logic [41:0] HBCDE00 = {7'b0000011, 7'b1000110, 7'b0100001,
                                     7'b0000110, 7'b1000000, 7'b1000000};
  localparam logic [41:0] RAW_PAT = 42'h2AA_5555_1234;
  localparam logic [41:0] RAW_EXP = 42'h155_AAAA_EDCB;

`ifdef HEX_DISPLAY_BLINK_EN
  localparam logic [41:0] BLINK_OFF = ALL;
`else
  localparam logic [41:0] BLINK_OFF = H0123AF;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  mode;
  logic [23:0] value;
  logic [41:0] raw_seg;
  logic        blink_en;
  logic        char_valid;
  logic        char_ready;
  logic [6:0]  char_seg;
  logic        msg_clear;
  logic [4:0]  msg_count;
  logic [41:0] hex_n;

  hex_display_ctrl #(.NUM_DIGITS(ND), .TICK_DIV(TD), .MSG_DEPTH(MD)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mode       (mode),
    .value      (value),
    .raw_seg    (raw_seg),
    .blink_en   (blink_en),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .char_seg   (char_seg),
    .msg_clear  (msg_clear),
    .msg_count  (msg_count),
    .hex_n      (hex_n)
  );

  always #5 clk = ~clk;

  int   cyc        = 0;
  int   checks     = 0;
  int   failures   = 0;
  int   m_tick_cnt = 0;
  logic tick_fired = 1'b0;

  // Reference tick: counts 0..TD-1 after reset; tick_fired marks an edge that consumed a tick.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset_n) begin
      m_tick_cnt <= 0;
      tick_fired <= 1'b0;
    end else begin
      m_tick_cnt <= (m_tick_cnt == TD - 1) ? 0 : m_tick_cnt + 1;
      tick_fired <= (m_tick_cnt == TD - 1);
    end
  end

  int          q_cyc  [$];
  logic [41:0] q_hex  [$];
  logic [41:0] q_mask [$];
  int          q_cnt  [$];
  int          q_rdy  [$];
  string       q_name [$];

  logic [6:0] m_buf [MD];
  int         m_cnt = 0;

  task automatic expect_at(input int dly, input string name, input logic [41:0] hex,
                           input logic [41:0] mask, input int cnt, input int rdy);
    q_cyc.push_back(cyc + dly);
    q_hex.push_back(hex);
    q_mask.push_back(mask);
    q_cnt.push_back(cnt);
    q_rdy.push_back(rdy);
    q_name.push_back(name);
  endtask

  always @(negedge clk) begin
    for (int i = q_cyc.size() - 1; i >= 0; i--) begin
      if (q_cyc[i] < cyc) begin
        checks++;
        failures++;
        $display("FAIL %s stale expectation cycle=%0d now=%0d", q_name[i], q_cyc[i], cyc);
      end else if (q_cyc[i] == cyc) begin
        if (q_mask[i] != '0) begin
          checks++;
          if ((hex_n & q_mask[i]) !== (q_hex[i] & q_mask[i])) begin
            failures++;
            $display("FAIL %s hex_n actual=%h required=%h", q_name[i], hex_n, q_hex[i]);
          end
        end
        if (q_cnt[i] >= 0) begin
          checks++;
          if (msg_count !== 5'(q_cnt[i])) begin
            failures++;
            $display("FAIL %s msg_count actual=%0d required=%0d", q_name[i], msg_count, q_cnt[i]);
          end
        end
        if (q_rdy[i] >= 0) begin
          checks++;
          if (char_ready !== 1'(q_rdy[i])) begin
            failures++;
            $display("FAIL %s char_ready actual=%b required=%0d", q_name[i], char_ready, q_rdy[i]);
          end
        end
      end
      if (q_cyc[i] <= cyc) begin
        q_cyc.delete(i);
        q_hex.delete(i);
        q_mask.delete(i);
        q_cnt.delete(i);
        q_rdy.delete(i);
        q_name.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!tick_fired && n < 2 * TD);
  endtask

  task automatic push_char(input logic [6:0] ch);
    char_valid = 1'b1;
    char_seg   = ch;
    if (m_cnt < MD) begin
      m_buf[m_cnt] = ch;
      m_cnt++;
    end
    step();
    char_valid = 1'b0;
  endtask

  function automatic logic [41:0] scroll_exp(input int cnt, input int ptr);
    logic [41:0] r;
    r = '1;
    for (int k = 0; k < ND; k++)
      if (k < cnt) r[7*(ND-1-k) +: 7] = ~m_buf[(ptr + k) % cnt];
    return r;
  endfunction

  initial begin
    reset_n = 1'b0; mode = 2'd0; value = '0; raw_seg = '0; blink_en = 1'b0;
    char_valid = 1'b0; char_seg = '0; msg_clear = 1'b0;
    repeat (3) step();
    expect_at(0, "reset_state", ALL, ALL, 0, 0);
    step();
    reset_n = 1'b1;
    expect_at(0, "ready_low_at_release", '0, '0, -1, 0);
    expect_at(1, "ready_rises", '0, '0, 0, 1);
    step();

    // HEX decode, RAW and BLANK
    value = 24'h0123AF; expect_at(1, "hex_0123AF", H0123AF, ALL, -1, -1); step();
    value = 24'h456789; expect_at(1, "hex_456789", H456789, ALL, -1, -1); step();
    value = 24'hBCDE00; expect_at(1, "hex_BCDE00", HBCDE00, ALL, -1, -1); step();
    mode = 2'd1; raw_seg = RAW_PAT; expect_at(1, "raw", RAW_EXP, ALL, -1, -1); step();
    mode = 2'd3; expect_at(1, "blank", ALL, ALL, -1, -1); step();

    // Blink on HEX glyphs
    mode = 2'd0; value = 24'h0123AF;
    wait_tick();
    blink_en = 1'b1;
    wait_tick();
    expect_at(1, "blink_t1", BLINK_OFF, ALL, -1, -1);
    expect_at(4, "blink_t1_hold", BLINK_OFF, ALL, -1, -1);
    wait_tick();
    expect_at(1, "blink_t2", H0123AF, ALL, -1, -1);
    wait_tick();
    expect_at(1, "blink_t3", BLINK_OFF, ALL, -1, -1);
    blink_en = 1'b0;
    expect_at(2, "blink_off", H0123AF, ALL, -1, -1);
    repeat (3) step();

    // Scroll through 8 characters
    for (int i = 0; i < 8; i++) push_char(7'((i + 1) * 17));
    expect_at(0, "count_8", '0, '0, 8, 1);
    mode = 2'd2;
    expect_at(1, "scroll_enter", scroll_exp(8, 0), ALL, 8, -1);
    step();
    wait_tick(); expect_at(1, "scroll_ptr1", scroll_exp(8, 1), ALL, -1, -1);
    wait_tick(); expect_at(1, "scroll_ptr2", scroll_exp(8, 2), ALL, -1, -1);
    repeat (5) wait_tick();
    expect_at(1, "scroll_ptr7", scroll_exp(8, 7), ALL, -1, -1);
    wait_tick(); expect_at(1, "scroll_wrap", scroll_exp(8, 0), ALL, -1, -1);
    step();

    // Reset mid-scroll
    reset_n = 1'b0;
    expect_at(1, "rst_mid", ALL, ALL, 0, 0);
    step();
    reset_n = 1'b1; m_cnt = 0;
    expect_at(1, "rst_mid_ready", ALL, ALL, 0, 1);
    step();

    // Short message stays put
    for (int i = 0; i < 3; i++) push_char(7'(64 + i * 5));
    expect_at(0, "short_count", '0, '0, 3, 1);
    for (int t = 0; t < 10; t++) begin
      wait_tick();
      expect_at(1, "short_hold", scroll_exp(3, 0), ALL, -1, -1);
    end
    step();

    // Full and clear
    mode = 2'd0;
    msg_clear = 1'b1;
    expect_at(0, "clear_ready_low", '0, '0, -1, 0);
    expect_at(1, "clear_count", '0, '0, 0, -1);
    step();
    msg_clear = 1'b0; m_cnt = 0;
    for (int i = 0; i < 16; i++) push_char(7'(i + 1));
    expect_at(0, "full", '0, '0, 16, 0);
    char_valid = 1'b1; char_seg = 7'h55;
    expect_at(1, "push_full_ignored", '0, '0, 16, 0);
    step();
    msg_clear = 1'b1;
    expect_at(1, "clear_full_push", '0, '0, 0, -1);
    step();
    msg_clear = 1'b0; char_valid = 1'b0; m_cnt = 0;
    push_char(7'h0F);
    push_char(7'h1E);
    msg_clear = 1'b1; char_valid = 1'b1; char_seg = 7'h2A;
    expect_at(1, "clear_beats_push", '0, '0, 0, -1);
    step();
    msg_clear = 1'b0; char_valid = 1'b0; m_cnt = 0;
    push_char(7'h3C);
    mode = 2'd2;
    expect_at(1, "after_clear_one", scroll_exp(1, 0), ALL, 1, -1);
    step();

    repeat (6) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hex_display_ctrl.md
HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 6, meaning the number of seven-segment digits driven (1..8).
REQ-002 The block SHALL have parameter TICK_DIV, default 12500000, meaning the clk cycles per scroll/blink tick (4 Hz at 50 MHz).
REQ-003 The block SHALL have parameter MSG_DEPTH, default 16, meaning the scroll-buffer capacity in characters (power of two, at least NUM_DIGITS).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port mode, input, 2 bits: 0 HEX, 1 RAW, 2 SCROLL, 3 BLANK.
REQ-007 The block SHALL have port value, input, 4*NUM_DIGITS bits: nibbles for HEX mode; digit 0 is rightmost and shows value[3:0].
REQ-008 The block SHALL have port raw_seg, input, 7*NUM_DIGITS bits: active-high segment patterns for RAW mode.
REQ-009 The block SHALL have port blink_en, input, 1 bit: when high, the display blanks on alternate ticks.
REQ-010 The block SHALL have ports char_valid (input, 1 bit), char_ready (output, 1 bit) and char_seg (input, 7 bits): the scroll-buffer push handshake.
REQ-011 The block SHALL have port msg_clear, input, 1 bit: empties the scroll buffer.
REQ-012 The block SHALL have port msg_count, output, $clog2(MSG_DEPTH)+1 bits: the number of characters held.
REQ-013 The block SHALL have port hex_n, output, 7*NUM_DIGITS bits: active-low segments; digit i occupies [7i+6:7i] with bit 0 = segment a.

Function
REQ-014 hex_n SHALL be registered, with 1 clk latency from any change on mode, value, raw_seg, buffer contents or tick-driven state.
REQ-015 In HEX mode, each digit SHALL show the standard 0-F glyph of its nibble.
REQ-016 In RAW mode, hex_n SHALL equal ~raw_seg.
REQ-017 In BLANK mode, hex_n SHALL be all ones.
REQ-018 The tick counter SHALL count 0..TICK_DIV-1, wrap to 0, and pulse tick for one cycle on the wrap.
REQ-019 A push SHALL be accepted when char_valid && char_ready; the character is written at index msg_count, and msg_count increments the next cycle.
REQ-020 char_ready SHALL be low when msg_count == MSG_DEPTH or msg_clear is high; a push while full is ignored.
REQ-021 msg_clear SHALL zero msg_count and the scroll pointer the next cycle, and clear SHALL win over a simultaneous push.
REQ-022 In SCROLL mode, digit NUM_DIGITS-1-k SHALL show buf[(ptr+k) mod msg_count] for k < msg_count, and digits with k >= msg_count SHALL be blank.
REQ-023 ptr SHALL advance on tick only in SCROLL mode with msg_count > NUM_DIGITS, wrapping from msg_count-1 to 0.
REQ-024 Entering SCROLL mode from any other mode SHALL reset ptr to 0.
REQ-025 A tick and a push in the same cycle SHALL both take effect.

Reset
REQ-026 While reset_n is low at a clk edge, the block SHALL reset: hex_n all ones, msg_count 0, ptr 0, tick counter 0, blink phase 0 (visible), char_ready 0.
REQ-027 char_ready SHALL rise 1 cycle after reset_n goes high.
REQ-028 Reset asserted mid-scroll SHALL discard the buffer contents.

Configuration
REQ-029 With HEX_DISPLAY_BLINK_EN defined, the blink phase SHALL toggle on each tick while blink_en is high, and hex_n SHALL be forced all ones while the phase is 1.
REQ-030 With HEX_DISPLAY_BLINK_EN defined, blink_en falling SHALL set the phase to 0.
REQ-031 Without HEX_DISPLAY_BLINK_EN, blink_en SHALL be ignored and no blink state SHALL exist.

Structure
REQ-032 The shared package hex_display_pkg SHALL hold the mode enum, the SEG_BLANK constant and the 16-entry active-high glyph table.
REQ-033 The block SHALL contain one sub-module, seg7_decode (nibble to active-high segments), instantiated once per digit.

Verification
REQ-034 The bench SHALL cover HEX decode: NUM_DIGITS=6, mode=0, value=24'h0123AF -> hex_n digit0=7'b0001110 (F), digit5=7'b1000000 (0), one cycle after the input is applied.
REQ-035 The bench SHALL cover scroll wrap: TICK_DIV=4, push 8 chars C0..C7, mode=2 -> leftmost digit shows C0, then C1, and after 8 ticks returns to C0.
REQ-036 The bench SHALL cover the short message: push 3 chars, mode=2 -> digits 5..3 show them, digits 2..0 are all ones, and nothing moves across 10 ticks.
REQ-037 The bench SHALL cover full and clear: push 16 chars, then char_ready=0 and a 17th push is ignored (msg_count=16); msg_clear with char_valid in the same cycle -> msg_count=0 and no write.
REQ-038 The bench SHALL cover blink (with the macro): blink_en=1, TICK_DIV=4 -> hex_n alternates between the glyphs and all ones every 4 cycles; without the macro -> no change.
REQ-039 The bench SHALL cover reset mid-scroll: reset_n low for 1 cycle -> hex_n all ones, msg_count=0, char_ready=0 then 1.
